// File: rtl/fifo_pkg.sv
// Shared helpers for the ring FIFO: pointer wrap and the count/pointer width functions.
package fifo_pkg;

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int pw_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Explicit compare-and-wrap, so a depth that is not a power of two needs no modulo.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ring_mem.sv
// N x M ring storage: one synchronous write port, one asynchronous read port.
module fifo_ring_mem #(
  parameter int N  = 4,
  parameter int M  = 2,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [M-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [M-1:0]  rdata
);

  logic [M-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read gives first-word fall-through at the top level.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with first-word fall-through, occupancy count and almost-full.
// Optional sticky overflow/underflow flags are built when FIFO_RING_ERR_FLAGS_EN is defined.
module fifo_ring
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 2,
  parameter int AF = N - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [M-1:0]        in,
  input  logic                push,
  input  logic                pop,
  input  logic                err_clr,
  output logic [M-1:0]        out,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic [cw_of(N)-1:0] count,
  output logic                overflow,
  output logic                underflow
);

  localparam int CW = cw_of(N);
  localparam int PW = pw_of(N);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [M-1:0]  head;
  logic          is_full;
  logic          is_empty;
  logic          do_push;
  logic          do_pop;

  assign is_full  = (cnt == CW'(N));
  assign is_empty = (cnt == '0);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_push = push && (!is_full || pop);
  assign do_pop  = pop && !is_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(ptr_next(int'(wr_ptr), N));
      if (do_pop)  rd_ptr <= PW'(ptr_next(int'(rd_ptr), N));
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  fifo_ring_mem #(
    .N (N),
    .M (M),
    .PW(PW)
  ) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(wr_ptr),
    .wdata(in),
    .raddr(rd_ptr),
    .rdata(head)
  );

  assign out         = is_empty ? '0 : head;
  assign full        = is_full;
  assign empty       = is_empty;
  assign almost_full = (cnt >= CW'(AF));
  assign count       = cnt;

`ifdef FIFO_RING_ERR_FLAGS_EN
  logic ovf_flag;
  logic unf_flag;
  logic ovf_set;
  logic unf_set;

  assign ovf_set = push && is_full && !pop;
  assign unf_set = pop && is_empty;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (ovf_set)      ovf_flag <= 1'b1;
      else if (err_clr) ovf_flag <= 1'b0;
      if (unf_set)      unf_flag <= 1'b1;
      else if (err_clr) unf_flag <= 1'b0;
    end
  end

  assign overflow  = ovf_flag;
  assign underflow = unf_flag;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// Directed, table-driven bench for fifo_ring (N=4 and N=5 builds, AF=2 variant).
`timescale 1ns/1ps
module tb_fifo_ring;

`ifdef FIFO_RING_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // N=4, M=2 stimulus shared by the AF=3 and AF=2 instances
  logic [1:0] in4 = '0;
  logic       push4 = 1'b0, pop4 = 1'b0, clr4 = 1'b0;
  logic [1:0] out4, out_af;
  logic       full4, empty4, af4, ovf4, unf4;
  logic       full_af, empty_af, af_af, ovf_af, unf_af;
  logic [2:0] count4, count_af;

  // N=5, M=3
  logic [2:0] in5 = '0;
  logic       push5 = 1'b0, pop5 = 1'b0, clr5 = 1'b0;
  logic [2:0] out5;
  logic       full5, empty5, af5, ovf5, unf5;
  logic [2:0] count5;

  fifo_ring #(.N(4), .M(2), .AF(3)) u4 (
    .clk(clk), .reset(reset), .in(in4), .push(push4), .pop(pop4), .err_clr(clr4),
    .out(out4), .full(full4), .empty(empty4), .almost_full(af4), .count(count4),
    .overflow(ovf4), .underflow(unf4));

  fifo_ring #(.N(4), .M(2), .AF(2)) u_af (
    .clk(clk), .reset(reset), .in(in4), .push(push4), .pop(pop4), .err_clr(clr4),
    .out(out_af), .full(full_af), .empty(empty_af), .almost_full(af_af), .count(count_af),
    .overflow(ovf_af), .underflow(unf_af));

  fifo_ring #(.N(5), .M(3), .AF(4)) u5 (
    .clk(clk), .reset(reset), .in(in5), .push(push5), .pop(pop5), .err_clr(clr5),
    .out(out5), .full(full5), .empty(empty5), .almost_full(af5), .count(count5),
    .overflow(ovf5), .underflow(unf5));

  typedef struct {
    logic       push, pop, clr;
    logic [1:0] din;
    logic [1:0] eout;
    int         ecnt;
    logic       efull, eempty, eaf, eovf, eunf;
  } vec_t;

  vec_t tbl[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic q, input logic c, input logic [1:0] d,
                     input logic [1:0] o, input int n, input logic f, input logic e,
                     input logic a, input logic ov, input logic un);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.din = d;
    v.eout = o; v.ecnt = n; v.efull = f; v.eempty = e; v.eaf = a;
    v.eovf = ov & ERR_EN; v.eunf = un & ERR_EN;
    tbl.push_back(v);
  endtask

  initial begin
    //   push pop clr din | out cnt full empty af ovf unf
    add(1,0,0,2'd1, 2'd1,1,0,0,0,0,0);
    add(1,0,0,2'd2, 2'd1,2,0,0,0,0,0);
    add(1,0,0,2'd3, 2'd1,3,0,0,1,0,0);
    add(1,0,0,2'd0, 2'd1,4,1,0,1,0,0);
    add(0,1,0,2'd0, 2'd2,3,0,0,1,0,0);
    add(0,1,0,2'd0, 2'd3,2,0,0,0,0,0);
    add(0,1,0,2'd0, 2'd0,1,0,0,0,0,0);
    add(0,1,0,2'd0, 2'd0,0,0,1,0,0,0);
    add(1,0,0,2'd1, 2'd1,1,0,0,0,0,0);
    add(1,0,0,2'd2, 2'd1,2,0,0,0,0,0);
    add(1,0,0,2'd3, 2'd1,3,0,0,1,0,0);
    add(1,0,0,2'd0, 2'd1,4,1,0,1,0,0);
    add(1,0,0,2'd2, 2'd1,4,1,0,1,1,0);   // push on full: dropped
    add(0,0,1,2'd0, 2'd1,4,1,0,1,0,0);   // clear overflow
    add(1,1,0,2'd3, 2'd2,4,1,0,1,0,0);   // push+pop while full
    add(1,1,0,2'd3, 2'd3,4,1,0,1,0,0);
    add(1,1,0,2'd3, 2'd0,4,1,0,1,0,0);
    add(1,1,0,2'd3, 2'd3,4,1,0,1,0,0);
    add(1,1,0,2'd3, 2'd3,4,1,0,1,0,0);
    add(1,1,0,2'd3, 2'd3,4,1,0,1,0,0);
    add(0,1,0,2'd0, 2'd3,3,0,0,1,0,0);
    add(0,1,0,2'd0, 2'd3,2,0,0,0,0,0);
    add(0,1,0,2'd0, 2'd3,1,0,0,0,0,0);
    add(0,1,0,2'd0, 2'd0,0,0,1,0,0,0);
    add(0,1,0,2'd0, 2'd0,0,0,1,0,0,1);   // pop on empty
    add(0,0,1,2'd0, 2'd0,0,0,1,0,0,0);
    add(1,1,0,2'd1, 2'd1,1,0,0,0,0,1);   // push+pop on empty
    add(0,1,1,2'd0, 2'd0,0,0,1,0,0,0);
    add(0,1,1,2'd0, 2'd0,0,0,1,0,0,1);   // new error beats clear
    add(0,0,1,2'd0, 2'd0,0,0,1,0,0,0);
    add(1,0,0,2'd1, 2'd1,1,0,0,0,0,0);
    add(1,0,0,2'd2, 2'd1,2,0,0,0,0,0);
    add(1,0,0,2'd3, 2'd1,3,0,0,1,0,0);
    add(1,0,0,2'd0, 2'd1,4,1,0,1,0,0);
    add(1,0,1,2'd2, 2'd1,4,1,0,1,1,0);   // overflow beats clear
    add(0,0,1,2'd0, 2'd1,4,1,0,1,0,0);
    add(0,1,0,2'd0, 2'd2,3,0,0,1,0,0);   // leave count=3 for the reset test

    // Reset state
    #12;
    check("rst_out", out4, 0);
    check("rst_empty", empty4, 1);
    check("rst_full", full4, 0);
    check("rst_count", count4, 0);
    check("rst_af", af4, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_unf", unf4, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      push4 = tbl[i].push; pop4 = tbl[i].pop; clr4 = tbl[i].clr; in4 = tbl[i].din;
      @(posedge clk);
      #1;
      $display("vec %0d: push=%0d pop=%0d clr=%0d in=%0d -> out=%0d count=%0d full=%0d empty=%0d af=%0d ovf=%0d unf=%0d",
               i, push4, pop4, clr4, in4, out4, count4, full4, empty4, af4, ovf4, unf4);
      check($sformatf("v%0d_out", i), out4, tbl[i].eout);
      check($sformatf("v%0d_count", i), count4, tbl[i].ecnt);
      check($sformatf("v%0d_full", i), full4, tbl[i].efull);
      check($sformatf("v%0d_empty", i), empty4, tbl[i].eempty);
      check($sformatf("v%0d_af", i), af4, tbl[i].eaf);
      check($sformatf("v%0d_ovf", i), ovf4, tbl[i].eovf);
      check($sformatf("v%0d_unf", i), unf4, tbl[i].eunf);
      check($sformatf("v%0d_af2", i), af_af, (tbl[i].ecnt >= 2) ? 1 : 0);
    end

    // Asynchronous reset mid-stream, checked before any clock edge
    @(negedge clk);
    push4 = 1'b0; pop4 = 1'b0; clr4 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: out=%0d empty=%0d count=%0d", out4, empty4, count4);
    check("arst_out", out4, 0);
    check("arst_empty", empty4, 1);
    check("arst_count", count4, 0);
    check("arst_full", full4, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push4 = 1'b1; in4 = 2'd2;
    @(posedge clk);
    #1;
    $display("post-reset push 2: out=%0d count=%0d", out4, count4);
    check("post_rst_out", out4, 2);
    check("post_rst_count", count4, 1);
    @(negedge clk);
    push4 = 1'b0;

    // N=5: prefill two words, then 12 push/pop pairs wrap the pointers
    push5 = 1'b1; in5 = 3'd1;
    @(negedge clk);
    in5 = 3'd2;
    @(posedge clk);
    #1;
    check("n5_prefill_count", count5, 2);
    check("n5_prefill_out", out5, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      push5 = 1'b1; pop5 = 1'b1; in5 = 3'((k + 3) & 7);
      @(posedge clk);
      #1;
      $display("n5 pair %0d: in=%0d -> out=%0d count=%0d", k, in5, out5, count5);
      check($sformatf("n5_p%0d_out", k), out5, (k + 2) & 7);
      check($sformatf("n5_p%0d_count", k), count5, 2);
    end
    @(negedge clk);
    push5 = 1'b0; pop5 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_ring.md
# fifo_ring

Parametrised circular-buffer FIFO, successor to the shift-register `fifo`, for buffering words between producer and consumer stages on one clock. Storage is a ring addressed by read and write pointers, so a push or pop moves no stored data. The head word is shown combinationally (first-word fall-through). Adds empty, occupancy count, a programmable almost-full threshold and optional sticky overflow/underflow error flags.

## Interface

Parameters:
- N, 4: depth in words; N ≥ 2; any integer, not limited to powers of two.
- M, 2: word width in bits; M ≥ 1.
- AF, N-1: almost_full threshold; 1 ≤ AF ≤ N.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in  input  M  word to push.
- push  input  1  write request.
- pop  input  1  read request; consumes the current `out`.
- err_clr  input  1  clears the sticky error flags.
- out  output  M  head (oldest) word; 0 when empty.
- full  output  1  count == N.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF.
- count  output  CW  occupancy, CW = $clog2(N+1).
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop was made while empty.

## Operation

- State: wr_ptr and rd_ptr, each PW = max(1, $clog2(N)) bits; count (CW bits); the error flags; storage W[0..N-1].
- Pointer advance: ptr == N-1 wraps to 0, otherwise ptr+1. No modulo on a non-power-of-two N.
- Accepted push: write W[wr_ptr] <= in, then advance wr_ptr.
- Accepted pop: advance rd_ptr.
- Each cycle, by case:
  - Push only, not full: accepted; count+1.
  - Push only, full: dropped; pointers and count unchanged; overflow <= 1.
  - Pop only, not empty: accepted; count-1.
  - Pop only, empty: ignored; underflow <= 1.
  - Push and pop, 0 < count < N: both accepted; count unchanged.
  - Push and pop, full: both accepted (the pop frees the slot); count stays N; no overflow.
  - Push and pop, empty: push accepted, pop ignored; count becomes 1; underflow <= 1.
- out = W[rd_ptr] when count > 0, else 0. Purely combinational from the registered state.
- err_clr: clears both flags on the next edge. A new error in the same cycle wins and the flag stays 1.
- Asynchronous reset assertion:
  - wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0.
  - W is not reset.
  - Outputs immediately: out = 0, empty = 1, full = 0, almost_full = 0.
- Reset mid-operation discards all queued words. The first accepted push after release lands in W[0].

## Timing

- Write-to-read latency: 1 cycle. A word pushed at edge k appears on out after edge k if the FIFO was empty.
- full, empty, almost_full and count are registered-state decodes. They change only after an edge or on reset assertion.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- No combinational path from push, pop or in to any output.
- Reset release is synchronised externally. The block assumes deassertion meets recovery/removal timing on clk.

## Configuration

- Macro: FIFO_RING_ERR_FLAGS_EN.
- Defined: overflow and underflow behave as in Operation; err_clr is honoured.
- Undefined:
  - overflow and underflow are tied to 0; err_clr is ignored; no flag registers exist.
  - Drop and ignore behaviour on misuse is unchanged.
- Ports are present in both builds.

## Structure

- Shared package fifo_pkg holds:
  - the ptr_next wrap function, parameterised by depth;
  - the width helper functions for CW and PW.
- Sub-module fifo_ring_mem: N×M storage with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The top level holds the pointers, count, flags and output decode.

## Test plan

- Reset, then push 0x1,0x2,0x3,0x0 with N=4, M=2 -> out 1,2,3,0 in order across four pops; full=1 after the 4th push; empty=1 after the 4th pop.
- Fill to N=4, then push 0x2 without pop -> count stays 4, out unchanged, overflow=1; pulse err_clr -> overflow=0 next cycle.
- Full FIFO, push 0x3 with pop for 6 cycles -> count stays 4, no overflow, words leave in push order, and pointers wrap correctly.
- N=5 (non-power-of-two), 12 push-pop pairs after prefilling 2 -> output order intact across wraps; count=2 throughout.
- Empty FIFO, push 0x1 with pop -> count=1, out=0x1, underflow=1; assert reset mid-stream with count=3 -> out=0, empty=1 immediately, without waiting for a clock edge.
- AF=2: count 1 -> almost_full=0; count 2 -> almost_full=1; build without FIFO_RING_ERR_FLAGS_EN, overfill -> overflow stays 0.
